a7_bus_link: RTL and testbench

//  Downstream consumer of the PS bus strobes do_a7_write/do_a7_read. Turns one bus access

---
 rtl/a7_bus_link.sv | 160 ++++++++++++++++
 tb/tb_a7_bus_link.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/a7_bus_link.sv
// Serial link master to the Artix-7 board: turns one PS bus access into a
// {rw,addr,data} frame, waits for an ack bit and, on reads, shifts back 16 bits.
module a7_bus_link #(
   parameter int CLKDIV  = 4,
   parameter int ACK_MAX = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        do_a7_write,
   input  logic        do_a7_read,
   input  logic [15:0] baddr,
   input  logic [15:0] bwrdata,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic [15:0] rddata,
   output logic        a7_csn,
   output logic        a7_sck,
   output logic        a7_mosi,
   input  logic        a7_miso
);

   localparam int HW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
   localparam int AW = (ACK_MAX > 1) ? $clog2(ACK_MAX + 1) : 1;
   localparam logic [HW-1:0] HRELOAD = HW'(CLKDIV - 1);
   localparam logic [AW-1:0] ACK_LAST = AW'(ACK_MAX - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SEND = 3'd1,
      WAIT = 3'd2,
      RECV = 3'd3,
      FIN  = 3'd4
   } state_t;

   state_t        state;
   logic [HW-1:0] hcnt;
   logic [32:0]   sreg;
   logic [15:0]   rsh;
   logic [5:0]    bcnt;
   logic [AW-1:0] wcnt;
   logic          rd_op;
   logic          no_ack;
   logic          tick;
   logic          rise;
   logic          fall;

   // rise/fall mark the clk edge on which the registered sck changes level
   assign tick = (hcnt == '0);
   assign rise = tick && !a7_sck;
   assign fall = tick && a7_sck;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         hcnt    <= '0;
         sreg    <= '0;
         rsh     <= '0;
         bcnt    <= '0;
         wcnt    <= '0;
         rd_op   <= 1'b0;
         no_ack  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         timeout <= 1'b0;
         rddata  <= '0;
         a7_csn  <= 1'b1;
         a7_sck  <= 1'b0;
         a7_mosi <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            hcnt <= '0;
            if (do_a7_write || do_a7_read) begin
               // write wins a simultaneous request; reads carry zero data
               sreg    <= do_a7_write ? {1'b0, baddr, bwrdata} : {1'b1, baddr, 16'h0000};
               rd_op   <= !do_a7_write;
               a7_mosi <= !do_a7_write;
               timeout <= 1'b0;
               no_ack  <= 1'b0;
               busy    <= 1'b1;
               a7_csn  <= 1'b0;
               a7_sck  <= 1'b0;
               hcnt    <= HRELOAD;
               bcnt    <= '0;
               wcnt    <= '0;
               state   <= SEND;
            end
         end else begin
            if (tick) begin
               hcnt   <= HRELOAD;
               a7_sck <= !a7_sck;
            end else begin
               hcnt <= hcnt - 1'b1;
            end

            case (state)
               SEND: begin
                  if (fall) begin
                     a7_mosi <= sreg[31];
                     sreg    <= {sreg[31:0], 1'b0};
                  end
                  if (rise) begin
                     if (bcnt == 6'd32) begin
                        bcnt  <= '0;
                        state <= WAIT;
                     end else begin
                        bcnt <= bcnt + 1'b1;
                     end
                  end
               end
               WAIT: begin
                  // mosi holds the last command bit through its high phase
                  if (fall) a7_mosi <= 1'b0;
                  if (rise) begin
                     if (a7_miso) begin
                        state <= rd_op ? RECV : FIN;
                     end else if (wcnt == ACK_LAST) begin
                        no_ack <= 1'b1;
                        state  <= FIN;
                     end else begin
                        wcnt <= wcnt + 1'b1;
                     end
                  end
               end
               RECV: begin
                  if (fall) a7_mosi <= 1'b0;
                  if (rise) begin
                     rsh <= {rsh[14:0], a7_miso};
                     if (bcnt == 6'd15) begin
                        rddata <= {rsh[14:0], a7_miso};
                        state  <= FIN;
                     end else begin
                        bcnt <= bcnt + 1'b1;
                     end
                  end
               end
               FIN: begin
                  // frame ends on the falling edge closing the last high phase
                  if (fall) begin
                     a7_mosi <= 1'b0;
                     a7_csn  <= 1'b1;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     timeout <= no_ack;
                     state   <= IDLE;
                  end
               end
               default: begin
                  a7_csn <= 1'b1;
                  a7_sck <= 1'b0;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_a7_bus_link.sv
// Bench for a7_bus_link: directed and random accesses against a behavioural
// A7 slave and a frame-level timing model.
module tb_a7_bus_link;

   localparam int CLKDIV  = 2;
   localparam int ACK_MAX = 8;
   localparam int LIMIT   = 1000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        do_a7_write = 1'b0;
   logic        do_a7_read = 1'b0;
   logic [15:0] baddr = '0;
   logic [15:0] bwrdata = '0;
   logic        busy;
   logic        done;
   logic        timeout;
   logic [15:0] rddata;
   logic        a7_csn;
   logic        a7_sck;
   logic        a7_mosi;
   logic        a7_miso = 1'b0;

   int checks = 0;
   int errors = 0;

   a7_bus_link #(.CLKDIV(CLKDIV), .ACK_MAX(ACK_MAX)) dut (
      .clk(clk), .rst_n(rst_n), .do_a7_write(do_a7_write), .do_a7_read(do_a7_read),
      .baddr(baddr), .bwrdata(bwrdata), .busy(busy), .done(done), .timeout(timeout),
      .rddata(rddata), .a7_csn(a7_csn), .a7_sck(a7_sck), .a7_mosi(a7_mosi), .a7_miso(a7_miso)
   );

   always #5 clk = ~clk;

   // slave model: rising sck numbered from 1 in each frame; 1..33 carry the
   // command, the ack sits on edge 34+ack_at, read data on the 16 after it
   int          s_ack_at = 0;
   logic        s_rd = 1'b0;
   logic [15:0] s_word = '0;
   int          s_edges = 0;
   logic [32:0] s_cap = '0;
   logic        s_prev_sck = 1'b0;

   function automatic logic slave_bit(input int e);
      if (s_ack_at < 0) return 1'b0;
      if (e == 34 + s_ack_at) return 1'b1;
      if (s_rd && e >= 35 + s_ack_at && e <= 50 + s_ack_at)
         return s_word[15 - (e - 35 - s_ack_at)];
      return 1'b0;
   endfunction

   always @(negedge clk) begin
      if (!rst_n || a7_csn) begin
         s_edges = 0;
         a7_miso = 1'b0;
      end else if (a7_sck && !s_prev_sck) begin
         s_edges++;
         if (s_edges <= 33) s_cap = {s_cap[31:0], a7_mosi};
         a7_miso = slave_bit(s_edges + 1);
      end
      s_prev_sck = a7_sck;
   end

   // done pulse counter and sck half-period monitor
   int   done_cnt = 0;
   int   phase_bad = 0;
   int   run_len = 0;
   logic in_frame = 1'b0;
   logic prev_lvl = 1'b0;

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (!rst_n) begin
         in_frame = 1'b0;
      end else if (!a7_csn) begin
         if (!in_frame) begin
            in_frame = 1'b1;
            run_len  = 1;
            prev_lvl = a7_sck;
         end else if (a7_sck == prev_lvl) begin
            run_len++;
         end else begin
            if (run_len != CLKDIV) phase_bad++;
            run_len  = 1;
            prev_lvl = a7_sck;
         end
      end else if (in_frame) begin
         in_frame = 1'b0;
         if (run_len != CLKDIV) phase_bad++;
      end
   end

   logic [15:0] exp_rd = '0;
   int          exp_done = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic start(input logic wr, input logic rd, input logic [15:0] a, input logic [15:0] d);
      @(posedge clk); #1;
      do_a7_write = wr;
      do_a7_read  = rd;
      baddr       = a;
      bwrdata     = d;
      @(posedge clk); #1;
      do_a7_write = 1'b0;
      do_a7_read  = 1'b0;
   endtask

   // ack_at < 0: slave never acks
   task automatic run(input logic wr, input logic rd, input logic [15:0] a, input logic [15:0] d,
                      input int ack_at, input logic [15:0] word, input logic poke);
      int          n;
      int          nbits;
      int          busy_low;
      int          csn_high;
      logic        eff_rd;
      logic [32:0] exp_cmd;
      eff_rd   = rd && !wr;
      s_ack_at = ack_at;
      s_rd     = eff_rd;
      s_word   = word;
      exp_cmd  = wr ? {1'b0, a, d} : {1'b1, a, 16'h0000};
      start(wr, rd, a, d);
      check("busy_after_accept", busy, 1);
      check("timeout_cleared", timeout, 0);
      n = 1; busy_low = 0; csn_high = 0;
      while (!done && n < LIMIT) begin
         if (!busy) busy_low++;
         if (a7_csn) csn_high++;
         do_a7_read = poke && (n == 20);
         @(posedge clk); #1;
         n++;
      end
      do_a7_read = 1'b0;
      check("done_seen", n < LIMIT, 1);
      nbits = 33 + ((ack_at >= 0) ? ack_at + 1 : ACK_MAX) + ((ack_at >= 0 && eff_rd) ? 16 : 0);
      // cycles from the start cycle to the done cycle, both included
      check("latency", n + 1, 2 * CLKDIV * nbits + 2);
      check("busy_frame", busy_low, 0);
      check("csn_frame", csn_high, 0);
      check("mosi_stream", s_cap, exp_cmd);
      check("idle_pins", {busy, a7_csn, a7_sck, a7_mosi}, 4'b0100);
      check("timeout", timeout, (ack_at < 0));
      if (eff_rd && ack_at >= 0) exp_rd = word;
      check("rddata", rddata, exp_rd);
      exp_done++;
   endtask

   initial begin
      int n;
      int ack;
      logic wr;
      logic rd;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_pins", {busy, done, timeout, a7_csn, a7_sck, a7_mosi}, 6'b000100);
      check("reset_rddata", rddata, 16'h0000);
      rst_n = 1'b1;

      run(1, 0, 16'h1234, 16'hBEEF, 0, 16'h0000, 0);
      run(0, 1, 16'h00A5, 16'h0000, 0, 16'hC3C3, 0);
      run(0, 1, 16'h1111, 16'h0000, -1, 16'hFFFF, 0);
      run(0, 1, 16'h2222, 16'h0000, 3, 16'h9A17, 0);
      run(1, 1, 16'h3333, 16'h4444, 0, 16'hAAAA, 0);
      run(1, 0, 16'h5555, 16'h6666, 1, 16'h0000, 1);
      run(1, 0, 16'h7777, 16'h8888, ACK_MAX - 1, 16'h0000, 0);

      // reset in the middle of the read-back phase
      s_ack_at = 0; s_rd = 1'b1; s_word = 16'h5A5A;
      start(0, 1, 16'h0ABC, 16'h0000);
      n = 0;
      while (s_edges < 40 && n < LIMIT) begin
         @(posedge clk); #1;
         n++;
      end
      check("reached_recv", n < LIMIT, 1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_pins", {busy, done, a7_csn, a7_sck}, 4'b0010);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      exp_rd = 16'h0000;
      check("abort_rddata", rddata, exp_rd);
      check("abort_no_done", done_cnt, exp_done);

      run(1, 0, 16'hCAFE, 16'hF00D, 2, 16'h0000, 0);
      run(1, 0, 16'h1234, 16'hBEEF, 0, 16'h0000, 0);
      run(1, 0, 16'h1234, 16'hBEEF, 0, 16'h0000, 0);

      for (int i = 0; i < 12; i++) begin
         wr  = 1'($urandom_range(0, 1));
         rd  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
         ack = $urandom_range(0, ACK_MAX);
         if (ack == ACK_MAX) ack = -1;
         repeat ($urandom_range(0, 3)) @(posedge clk);
         run(wr, rd, 16'($urandom), 16'($urandom), ack, 16'($urandom), 1'($urandom_range(0, 1)));
      end

      repeat (20) @(posedge clk);
      #1;
      check("done_count", done_cnt, exp_done);
      check("sck_half_period", phase_bad, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
